// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t : arbiter FSM states (ST_IDLE, ST_GRANT, ST_RESP)
//   sel_t   : which processor port owns the current transfer (SEL_I fetch, SEL_D data)
//   TIMER_W : width of the GRANT wait timer
//   BURST_W : width of the consecutive data grant counter
package mem_port_arbiter_pkg;

   localparam int TIMER_W = 16;
   localparam int BURST_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } sel_t;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait timer for the GRANT phase: counts cycles spent waiting for m_ack.
//   clk    : clock
//   reset  : synchronous active-high reset
//   clear  : force the count to zero (entry into GRANT)
//   enable : advance the count by one
//   term   : count has reached TIMEOUT-1
module mem_port_arbiter_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic term
);

   localparam logic [TIMER_W-1:0] TERM_CNT = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] count_r;

   // Wait counter: clear has priority over enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (clear) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (enable) begin
         count_r <= count_r + TIMER_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign term = (count_r == TERM_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data ports.
//   clk, reset                       : clock, synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack    : fetch port (load only)
//   d_req/d_we/d_addr/d_wdata
//                -> d_rdata/d_ack    : data port (load or store)
//   m_req/m_we/m_addr/m_wdata,
//   m_rdata/m_ack                    : memory bus, held stable while m_req is high
//   err                              : pulses with the ack of a timed-out transfer
//   stall                            : combinational, processor has an access outstanding
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              err,
   output logic              stall
);

   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

   state_t             state_r;
   state_t             state_s;
   sel_t               sel_r;
   logic [BURST_W-1:0] burst_cnt_r;
   logic               win_d_s;
   logic               grant_s;
   logic               done_ok_s;
   logic               done_to_s;
   logic               timer_en_s;
   logic               timer_term_s;

   mem_port_arbiter_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (grant_s),
      .enable (timer_en_s),
      .term   (timer_term_s)
   );

   // Next-state and transfer strobes; data wins unless fetch has waited out a full burst.
   always_comb begin
      state_s    = state_r;
      grant_s    = 1'b0;
      done_ok_s  = 1'b0;
      done_to_s  = 1'b0;
      timer_en_s = 1'b0;
      win_d_s    = d_req & ~((burst_cnt_r == BURST_MAX) & i_req);
      case (state_r)
         ST_IDLE: begin
            if (i_req | d_req) begin
               grant_s = 1'b1;
               state_s = ST_GRANT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (m_ack) begin
               done_ok_s = 1'b1;
               state_s   = ST_RESP;
            end else if (timer_term_s) begin
               done_to_s = 1'b1;
               state_s   = ST_RESP;
            end else begin
               timer_en_s = 1'b1;
               state_s    = ST_GRANT;
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Bus drive, grant bookkeeping and completion outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_r       <= SEL_I;
         burst_cnt_r <= {BURST_W{1'b0}};
         m_req       <= 1'b0;
         m_we        <= 1'b0;
         m_addr      <= {ADDR_W{1'b0}};
         m_wdata     <= {DATA_W{1'b0}};
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         err         <= 1'b0;
         i_rdata     <= {DATA_W{1'b0}};
         d_rdata     <= {DATA_W{1'b0}};
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err   <= 1'b0;
         if (grant_s) begin
            m_req <= 1'b1;
            if (win_d_s) begin
               sel_r   <= SEL_D;
               m_we    <= d_we;
               m_addr  <= d_addr;
               m_wdata <= d_wdata;
               if (burst_cnt_r != BURST_MAX) begin
                  burst_cnt_r <= burst_cnt_r + BURST_W'(1);
               end
            end else begin
               sel_r       <= SEL_I;
               m_we        <= 1'b0;
               m_addr      <= i_addr;
               burst_cnt_r <= {BURST_W{1'b0}};
            end
         end else if (done_ok_s || done_to_s) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            err   <= done_to_s;
            if (sel_r == SEL_D) begin
               d_ack <= 1'b1;
               if (done_to_s) begin
                  d_rdata <= {DATA_W{1'b0}};
               end else if (!m_we) begin
                  d_rdata <= m_rdata;
               end
            end else begin
               i_ack <= 1'b1;
               if (done_to_s) begin
                  i_rdata <= {DATA_W{1'b0}};
               end else begin
                  i_rdata <= m_rdata;
               end
            end
         end
      end
   end

   assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          len;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] mem_rdata;
   logic        m_ack;
   logic        err;
   logic        stall;

   logic        resp_ack;
   logic        stray_ack;
   logic        mem_en;
   int          mem_lat;
   int          resp_cnt;
   logic [31:0] cap_addr;
   logic        cap_we;
   logic [31:0] cap_wdata;
   int          cap_len;

   exp_t        sb_q[$];
   int          pass_cnt;
   int          total_cnt;
   int          ack_seen;
   logic [31:0] exp_d;

   assign m_ack = resp_ack | stray_ack;

   mem_port_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .MAX_DATA_BURST (4),
      .TIMEOUT        (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (mem_rdata),
      .m_ack   (m_ack),
      .err     (err),
      .stall   (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Memory model: acknowledges mem_lat cycles after m_req rises, records bus contents.
   initial begin
      resp_cnt = 0;
      resp_ack = 1'b0;
      cap_addr = 32'h0;
      cap_we = 1'b0;
      cap_wdata = 32'h0;
      cap_len = 0;
      forever begin
         @(negedge clk);
         if (m_req) begin
            cap_addr  = m_addr;
            cap_we    = m_we;
            cap_wdata = m_wdata;
            cap_len   = resp_cnt + 1;
            resp_ack  = mem_en && (resp_cnt == mem_lat);
            resp_cnt++;
         end else begin
            resp_cnt = 0;
            resp_ack = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every ack pops one expected transfer.
   initial begin
      exp_t e;
      ack_seen = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (i_ack || d_ack) begin
               ack_seen++;
               check("ack_onehot", {31'h0, i_ack & d_ack}, 32'h0);
               if (sb_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b expected no ack", i_ack, d_ack);
               end else begin
                  e = sb_q.pop_front();
                  check("ack_port", {31'h0, d_ack}, {31'h0, e.is_d});
                  check("err", {31'h0, err}, {31'h0, e.err});
                  check("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                  check("bus_addr", cap_addr, e.addr);
                  check("bus_we", {31'h0, cap_we}, {31'h0, e.we});
                  if (e.we) check("bus_wdata", cap_wdata, e.wdata);
                  check("mreq_len", cap_len, e.len);
               end
            end else if (err) begin
               total_cnt++;
               $display("FAIL err_without_ack: got err=1 expected 0");
            end
         end
      end
   end

   task automatic push_exp(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic e_err, input int len);
      exp_t e;
      e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
      e.rdata = rdata; e.err = e_err; e.len = len;
      sb_q.push_back(e);
   endtask

   // One complete transfer on a single port, dropping the request after its ack.
   task automatic do_req(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_len);
      int  n;
      bit  got;
      push_exp(is_d, we, addr, wdata, exp_rdata, exp_err, exp_len);
      @(posedge clk); #1;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      got = 1'b0;
      n = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1) check("stall_wait", {31'h0, stall}, 32'h1);
         if ((is_d && d_ack) || (!is_d && i_ack)) got = 1'b1;
      end
      if (!got) begin
         total_cnt++;
         $display("FAIL ack_timeout: got no ack in %0d cycles expected ack", n);
      end else begin
         check("ack_latency", n, exp_len + 2);
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1;
      check("stall_idle", {31'h0, stall}, 32'h0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_req"}, {31'h0, m_req}, 32'h0);
      check({tag, "_m_we"}, {31'h0, m_we}, 32'h0);
      check({tag, "_m_addr"}, m_addr, 32'h0);
      check({tag, "_m_wdata"}, m_wdata, 32'h0);
      check({tag, "_acks_err"}, {29'h0, i_ack, d_ack, err}, 32'h0);
      check({tag, "_i_rdata"}, i_rdata, 32'h0);
      check({tag, "_d_rdata"}, d_rdata, 32'h0);
   endtask

   initial begin
      int base;
      int n;
      pass_cnt = 0; total_cnt = 0;
      reset = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      mem_rdata = 32'h0; mem_en = 1'b1; mem_lat = 0; stray_ack = 1'b0;
      exp_d = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst");
      check("rst_stall", {31'h0, stall}, 32'h0);

      // Single fetch, zero-latency memory.
      mem_lat = 0; mem_rdata = 32'h2008000A;
      do_req(1'b0, 1'b0, 32'h00400000, 32'h0, 32'h2008000A, 1'b0, 1);

      // Load to give d_rdata a known value.
      mem_lat = 1; mem_rdata = 32'h55AA33CC;
      do_req(1'b1, 1'b0, 32'h00000020, 32'h0, 32'h55AA33CC, 1'b0, 2);
      exp_d = 32'h55AA33CC;

      // Store with 3 wait cycles: d_rdata must keep the previous load value.
      mem_lat = 3; mem_rdata = 32'h11111111;
      do_req(1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, exp_d, 1'b0, 4);

      // Stray m_ack while idle, then held through a load and its RESP cycle.
      @(posedge clk); #1;
      stray_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      repeat (4) @(negedge clk);
      check("stray_idle_m_req", {31'h0, m_req}, 32'h0);
      check("stray_idle_d_rdata", d_rdata, exp_d);
      check("stray_idle_i_rdata", i_rdata, 32'h2008000A);
      do_req(1'b1, 1'b0, 32'h00000030, 32'h0, 32'hBAD0BAD0, 1'b0, 1);
      exp_d = 32'hBAD0BAD0;
      mem_rdata = 32'h77777777;
      repeat (3) @(negedge clk);
      check("stray_after_d_rdata", d_rdata, exp_d);
      check("stray_after_m_req", {31'h0, m_req}, 32'h0);
      @(posedge clk); #1 stray_ack = 1'b0;

      // Timeout: no m_ack for a load, then a normal load.
      mem_en = 1'b0;
      do_req(1'b1, 1'b0, 32'h00000044, 32'h0, 32'h0, 1'b1, 8);
      mem_en = 1'b1; mem_lat = 0; mem_rdata = 32'h0BADF00D;
      do_req(1'b1, 1'b0, 32'h00000048, 32'h0, 32'h0BADF00D, 1'b0, 1);

      // Contention from reset: pattern of 4 data grants then 1 fetch grant.
      apply_reset();
      mem_lat = 1; mem_rdata = 32'h0C0FFEE0;
      for (int k = 0; k < 10; k++) begin
         if ((k % 5) == 4) push_exp(1'b0, 1'b0, 32'h00000100, 32'h0, 32'h0C0FFEE0, 1'b0, 2);
         else              push_exp(1'b1, 1'b0, 32'h00000200, 32'h0, 32'h0C0FFEE0, 1'b0, 2);
      end
      base = ack_seen;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h00000100;
      d_req = 1'b1; d_addr = 32'h00000200; d_we = 1'b0;
      n = 0;
      while ((ack_seen - base) < 10 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if ((ack_seen - base) < 10) begin
         total_cnt++;
         $display("FAIL contention_timeout: got %0d acks expected 10", ack_seen - base);
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;

      // Reset asserted while a load waits in GRANT.
      mem_en = 1'b0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000080;
      repeat (3) @(negedge clk);
      check("pre_reset_m_req", {31'h0, m_req}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1; d_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk); #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_reset_m_req", {31'h0, m_req}, 32'h0);
      mem_en = 1'b1; mem_lat = 2; mem_rdata = 32'h600DCAFE;
      do_req(1'b1, 1'b0, 32'h00000084, 32'h0, 32'h600DCAFE, 1'b0, 3);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
